// File: rtl/wbu.sv
// Write-back stage: commits GPR/CSR results, handles ecall/mret and hands the next PC to the IFU.
// Optional macro WBU_RF_BYPASS_EN forwards pending COMMIT writes onto the read ports.
module wbu #(
  parameter logic [31:0] RESET_PC    = 32'h8000_0000,
  parameter logic [31:0] MSTATUS_RST = 32'h0000_1800,
  parameter logic [31:0] ECALL_CAUSE = 32'd11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbu_receive_valid,
  output logic        wbu_receive_ready,
  input  logic [31:0] wd,
  input  logic [31:0] csr_wd,
  input  logic [4:0]  rd,
  input  logic [1:0]  csr_rd,
  input  logic        reg_write_en,
  input  logic        csreg_write_en,
  input  logic        ecall,
  input  logic        mret,
  input  logic [31:0] pc,
  input  logic [31:0] pc_next,
  input  logic [31:0] instruction,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic [31:0] src1,
  output logic [31:0] src2,
  input  logic [1:0]  csr_raddr,
  output logic [31:0] csr_rdata,
  output logic        wbu_send_valid,
  input  logic        ifu_receive_ready,
  output logic [31:0] dnpc,
  output logic [63:0] retire_count,
  output logic        wbu_state
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] COMMIT = 2'd1;
  localparam logic [1:0] SEND   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [31:0][31:0] gpr_q, gpr_view;
  // CSR index: 0 mstatus, 1 mtvec, 2 mepc, 3 mcause
  logic [3:0][31:0]  csr_q, csr_d, csr_view;
  logic [31:0]       dnpc_q, dnpc_commit;
  logic [63:0]       retire_q;

  logic [31:0] wd_q, csr_wd_q, pc_q, pc_next_q;
  logic [4:0]  rd_q;
  logic [1:0]  csr_rd_q;
  logic        reg_we_q, csr_we_q, ecall_q, mret_q;
  logic        accept, commit, gpr_we;

  assign accept = (state_q == IDLE) && wbu_receive_valid;
  assign commit = (state_q == COMMIT);
  assign gpr_we = commit && reg_we_q && (rd_q != 5'd0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (wbu_receive_valid) state_d = COMMIT;
      COMMIT:  state_d = SEND;
      SEND:    if (ifu_receive_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ecall overrides any CSR write; mret still allows one.
  always_comb begin
    csr_d = csr_q;
    if (ecall_q) begin
      csr_d[2] = pc_q;
      csr_d[3] = ECALL_CAUSE;
    end else if (csr_we_q) begin
      csr_d[csr_rd_q] = csr_wd_q;
    end
    dnpc_commit = ecall_q ? csr_q[1] : (mret_q ? csr_q[2] : pc_next_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      wd_q      <= '0;
      csr_wd_q  <= '0;
      pc_q      <= '0;
      pc_next_q <= '0;
      rd_q      <= '0;
      csr_rd_q  <= '0;
      reg_we_q  <= 1'b0;
      csr_we_q  <= 1'b0;
      ecall_q   <= 1'b0;
      mret_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wd_q      <= wd;
        csr_wd_q  <= csr_wd;
        pc_q      <= pc;
        pc_next_q <= pc_next;
        rd_q      <= rd;
        csr_rd_q  <= csr_rd;
        reg_we_q  <= reg_write_en;
        csr_we_q  <= csreg_write_en;
        ecall_q   <= ecall;
        mret_q    <= mret;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpr_q    <= '0;
      csr_q    <= {32'd0, 32'd0, 32'd0, MSTATUS_RST};
      dnpc_q   <= RESET_PC;
      retire_q <= '0;
    end else if (commit) begin
      if (gpr_we) gpr_q[rd_q] <= wd_q;
      csr_q    <= csr_d;
      dnpc_q   <= dnpc_commit;
      retire_q <= retire_q + 64'd1;
    end
  end

  always_comb begin
    gpr_view = gpr_q;
    csr_view = csr_q;
`ifdef WBU_RF_BYPASS_EN
    if (gpr_we) gpr_view[rd_q] = wd_q;
    if (commit) csr_view = csr_d;
`endif
  end

  assign src1              = (rs1 == 5'd0) ? 32'd0 : gpr_view[rs1];
  assign src2              = (rs2 == 5'd0) ? 32'd0 : gpr_view[rs2];
  assign csr_rdata         = csr_view[csr_raddr];
  assign wbu_receive_ready = (state_q == IDLE);
  assign wbu_send_valid    = (state_q == SEND);
  assign wbu_state         = (state_q != IDLE);
  assign dnpc              = dnpc_q;
  assign retire_count      = retire_q;

endmodule

// File: tb/tb_wbu.sv
// Self-checking bench for wbu: transaction-level reference model, directed cases, then random traffic.
module tb_wbu;
  logic        clk = 1'b0;
  logic        rst;
  logic        wbu_receive_valid, wbu_receive_ready;
  logic [31:0] wd, csr_wd, pc, pc_next, instruction;
  logic [4:0]  rd, rs1, rs2;
  logic [1:0]  csr_rd, csr_raddr;
  logic        reg_write_en, csreg_write_en, ecall, mret;
  logic [31:0] src1, src2, csr_rdata, dnpc;
  logic        wbu_send_valid, ifu_receive_ready, wbu_state;
  logic [63:0] retire_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wbu dut (
    .clk(clk), .rst(rst),
    .wbu_receive_valid(wbu_receive_valid), .wbu_receive_ready(wbu_receive_ready),
    .wd(wd), .csr_wd(csr_wd), .rd(rd), .csr_rd(csr_rd),
    .reg_write_en(reg_write_en), .csreg_write_en(csreg_write_en),
    .ecall(ecall), .mret(mret), .pc(pc), .pc_next(pc_next), .instruction(instruction),
    .rs1(rs1), .rs2(rs2), .src1(src1), .src2(src2),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .wbu_send_valid(wbu_send_valid), .ifu_receive_ready(ifu_receive_ready),
    .dnpc(dnpc), .retire_count(retire_count), .wbu_state(wbu_state)
  );

  // Reference model: architectural state plus the one in-flight instruction.
  logic [31:0] m_gpr [32];
  logic [31:0] m_csr [4];
  logic [31:0] m_dnpc;
  logic [63:0] m_ret;
  int          m_phase; // 0 waiting, 1 committing, 2 offering dnpc
  logic [31:0] t_wd, t_csr_wd, t_pc, t_pcn;
  logic [4:0]  t_rd;
  logic [1:0]  t_csr_rd;
  logic        t_rwe, t_cwe, t_ecall, t_mret;

  function automatic void model_reset();
    foreach (m_gpr[i]) m_gpr[i] = 32'd0;
    m_csr[0] = 32'h0000_1800;
    m_csr[1] = 32'd0;
    m_csr[2] = 32'd0;
    m_csr[3] = 32'd0;
    m_dnpc   = 32'h8000_0000;
    m_ret    = 64'd0;
    m_phase  = 0;
    {t_wd, t_csr_wd, t_pc, t_pcn, t_rd, t_csr_rd, t_rwe, t_cwe, t_ecall, t_mret} = '0;
  endfunction

  function automatic void model_edge();
    if (!rst) begin
      model_reset();
      return;
    end
    if (m_phase == 0) begin
      if (wbu_receive_valid) begin
        t_wd = wd; t_csr_wd = csr_wd; t_pc = pc; t_pcn = pc_next; t_rd = rd;
        t_csr_rd = csr_rd; t_rwe = reg_write_en; t_cwe = csreg_write_en;
        t_ecall = ecall; t_mret = mret;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (t_rwe && t_rd != 5'd0) m_gpr[t_rd] = t_wd;
      if (t_ecall) begin
        m_dnpc   = m_csr[1];
        m_csr[2] = t_pc;
        m_csr[3] = 32'd11;
      end else begin
        m_dnpc = t_mret ? m_csr[2] : t_pcn;
        if (t_cwe) m_csr[t_csr_rd] = t_csr_wd;
      end
      m_ret   = m_ret + 64'd1;
      m_phase = 2;
    end else if (ifu_receive_ready) begin
      m_phase = 0;
    end
  endfunction

  function automatic logic [31:0] gpr_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef WBU_RF_BYPASS_EN
    if (m_phase == 1 && t_rwe && t_rd != 5'd0 && a == t_rd) return t_wd;
`endif
    return m_gpr[a];
  endfunction

  function automatic logic [31:0] csr_read(input logic [1:0] a);
`ifdef WBU_RF_BYPASS_EN
    if (m_phase == 1) begin
      if (t_ecall && a == 2'd2) return t_pc;
      if (t_ecall && a == 2'd3) return 32'd11;
      if (!t_ecall && t_cwe && a == t_csr_rd) return t_csr_wd;
    end
`endif
    return m_csr[a];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    chk("ready", wbu_receive_ready, m_phase == 0);
    chk("send_valid", wbu_send_valid, m_phase == 2);
    chk("wbu_state", wbu_state, m_phase != 0);
    chk("dnpc", dnpc, m_dnpc);
    chk("retire_count", retire_count, m_ret);
    chk("src1", src1, gpr_read(rs1));
    chk("src2", src2, gpr_read(rs2));
    chk("csr_rdata", csr_rdata, csr_read(csr_raddr));
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    if (!rst) model_reset();
    #1 check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    wbu_receive_valid = 0; wd = 0; csr_wd = 0; rd = 0; csr_rd = 0; reg_write_en = 0;
    csreg_write_en = 0; ecall = 0; mret = 0; pc = 0; pc_next = 0; instruction = 0;
    rs1 = 0; rs2 = 0; csr_raddr = 0; ifu_receive_ready = 1;
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_dnpc", dnpc, 64'h8000_0000);
    chk("rst_send_valid", wbu_send_valid, 0);
    chk("rst_ready", wbu_receive_ready, 1);
    chk("rst_mstatus", csr_rdata, 64'h1800);
    chk("rst_retire", retire_count, 0);

    // ALU retire
    wbu_receive_valid = 1; rd = 5; wd = 32'hDEAD_BEEF; reg_write_en = 1;
    pc_next = 32'h8000_0004; rs1 = 5;
    step();
    wbu_receive_valid = 0;
    step();
    #1;
    chk("alu_src1", src1, 64'hDEAD_BEEF);
    chk("alu_dnpc", dnpc, 64'h8000_0004);
    chk("alu_valid", wbu_send_valid, 1);
    chk("alu_retire", retire_count, 1);
    step();
    chk("alu_valid_one_cycle", wbu_send_valid, 0);

    // x0 write discarded
    clear_inputs();
    wbu_receive_valid = 1; rd = 0; wd = 32'h1234; reg_write_en = 1; pc_next = 32'h8000_0008;
    step();
    wbu_receive_valid = 0;
    repeat (2) step();
    chk("x0_src1", src1, 0);

    // mtvec setup, then ecall that also requests a CSR write
    clear_inputs();
    wbu_receive_valid = 1; csr_rd = 1; csr_wd = 32'h8000_0100; csreg_write_en = 1;
    pc_next = 32'h8000_000C;
    step();
    wbu_receive_valid = 0;
    repeat (2) step();
    clear_inputs();
    wbu_receive_valid = 1; ecall = 1; pc = 32'h8000_0040; csreg_write_en = 1; csr_rd = 1;
    csr_wd = 32'h1111_2222; pc_next = 32'h8000_0044;
    step();
    wbu_receive_valid = 0; ecall = 0;
    step();
    chk("ecall_dnpc", dnpc, 64'h8000_0100);
    csr_raddr = 2; #1 chk("ecall_mepc", csr_rdata, 64'h8000_0040);
    csr_raddr = 3; #1 chk("ecall_mcause", csr_rdata, 64'd11);
    csr_raddr = 1; #1 chk("ecall_mtvec", csr_rdata, 64'h8000_0100);
    step();

    // Backpressure with upstream valid held throughout
    clear_inputs();
    wbu_receive_valid = 1; rd = 9; wd = 32'hA5A5_0009; reg_write_en = 1;
    pc_next = 32'h8000_0200; ifu_receive_ready = 0;
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_valid", wbu_send_valid, 1);
      chk("bp_ready", wbu_receive_ready, 0);
      chk("bp_dnpc", dnpc, 64'h8000_0200);
      step();
    end
    ifu_receive_ready = 1;
    step();
    chk("bp_ready_back", wbu_receive_ready, 1);
    step();
    chk("bp_held_accepted", wbu_state, 1);
    wbu_receive_valid = 0;
    repeat (2) step();

    // Async reset while an rd=7 write is committing
    clear_inputs();
    wbu_receive_valid = 1; rd = 7; wd = 32'h0000_7777; reg_write_en = 1; rs1 = 7;
    step();
    wbu_receive_valid = 0;
    rst = 1'b0;
    #1;
    chk("rstmid_state", wbu_state, 0);
    chk("rstmid_retire", retire_count, 0);
    chk("rstmid_gpr7", src1, 0);
    repeat (2) step();
    rst = 1'b1;
    step();
    chk("rstmid_gpr7_after", src1, 0);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      rst               = ($urandom_range(0, 799) != 0);
      wbu_receive_valid = $urandom_range(0, 1);
      wd                = $urandom;
      csr_wd            = $urandom;
      rd                = 5'($urandom_range(0, 31));
      csr_rd            = 2'($urandom_range(0, 3));
      reg_write_en      = ($urandom_range(0, 3) != 0);
      csreg_write_en    = $urandom_range(0, 1);
      ecall             = ($urandom_range(0, 7) == 0);
      mret              = ($urandom_range(0, 7) == 0);
      pc                = $urandom;
      pc_next           = $urandom;
      instruction       = $urandom;
      rs1               = 5'($urandom_range(0, 31));
      rs2               = 5'($urandom_range(0, 31));
      csr_raddr         = 2'($urandom_range(0, 3));
      ifu_receive_ready = ($urandom_range(0, 9) < 6);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
